// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-beat round-robin arbiter sharing one memory port between fetch (F) and data (D).
// Define MEM_ARBITER_PERF_EN to add per-requester stall counters.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_f_req,
  input  logic [ADDR_WIDTH-1:0] i_f_addr,
  output logic                  o_f_gnt,
  output logic                  o_f_rvalid,
  input  logic                  i_d_req,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic                  i_d_we,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_d_gnt,
  output logic                  o_d_rvalid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_data
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [15:0]           o_f_stall_cnt,
  output logic [15:0]           o_d_stall_cnt
`endif
);

  typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  owner_t     owner, winner;
  logic       last_d;
  logic [3:0] beat_cnt;
  logic       rv_f, rv_d;
  logic       f_req, d_req, under_limit;

  always_comb begin
    winner      = OWN_NONE;
    f_req       = i_f_req & i_rst_n;
    d_req       = i_d_req & i_rst_n;
    under_limit = (beat_cnt < MAX_B);
    // The current owner keeps the port until it stops asking or exhausts its burst while the other waits.
    if (owner == OWN_F && f_req && (!d_req || under_limit))
      winner = OWN_F;
    else if (owner == OWN_D && d_req && (!f_req || under_limit))
      winner = OWN_D;
    else if (f_req && !d_req)
      winner = OWN_F;
    else if (d_req && !f_req)
      winner = OWN_D;
    else if (f_req && d_req)
      winner = last_d ? OWN_F : OWN_D;
  end

  always_comb begin
    o_f_gnt     = (winner == OWN_F);
    o_d_gnt     = (winner == OWN_D);
    o_mem_addr  = '0;
    o_mem_write = 1'b0;
    o_mem_wdata = '0;
    if (winner == OWN_D) begin
      o_mem_addr  = i_d_addr;
      o_mem_write = i_d_we;
      o_mem_wdata = i_d_wdata;
    end else if (winner == OWN_F) begin
      o_mem_addr  = i_f_addr;
    end
    o_f_rvalid = rv_f;
    o_d_rvalid = rv_d;
    o_rdata    = i_rst_n ? i_mem_data : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      owner    <= OWN_NONE;
      last_d   <= 1'b1;
      beat_cnt <= 4'd0;
      rv_f     <= 1'b0;
      rv_d     <= 1'b0;
    end else begin
      owner <= winner;
      if (winner == OWN_NONE)
        beat_cnt <= 4'd0;
      else if (winner == owner)
        beat_cnt <= (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;
      else
        beat_cnt <= 4'd1;
      if (winner != OWN_NONE)
        last_d <= (winner == OWN_D);
      rv_f <= (winner == OWN_F);
      rv_d <= (winner == OWN_D) & ~i_d_we;
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_f_stall_cnt <= 16'd0;
      o_d_stall_cnt <= 16'd0;
    end else begin
      if (i_f_req && !o_f_gnt && o_f_stall_cnt != 16'hFFFF)
        o_f_stall_cnt <= o_f_stall_cnt + 16'd1;
      if (i_d_req && !o_d_gnt && o_d_stall_cnt != 16'hFFFF)
        o_d_stall_cnt <= o_d_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter against a behavioural arbitration and memory model.
// Stall counter checks are active when MEM_ARBITER_PERF_EN is defined.
module tb_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] f_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          f_gnt, f_rvalid, d_gnt, d_rvalid, mem_write;
  logic [DW-1:0] rdata, mem_wdata, mem_q = '0;
  logic [AW-1:0] mem_addr;
`ifdef MEM_ARBITER_PERF_EN
  logic [15:0]   f_stall, d_stall;
`endif

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAX_BURST)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt), .o_f_rvalid(f_rvalid),
    .i_d_req(d_req), .i_d_addr(d_addr), .i_d_we(d_we), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_rdata(rdata),
    .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_wdata(mem_wdata),
    .i_mem_data(mem_q)
`ifdef MEM_ARBITER_PERF_EN
    , .o_f_stall_cnt(f_stall), .o_d_stall_cnt(d_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [7:0] init_val(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
  endfunction

  // Synchronous byte memory seen by the DUT: data appears the cycle after the address.
  logic [7:0] env_mem [int];
  always @(posedge clk) begin
    mem_q <= env_mem.exists(int'(mem_addr)) ? env_mem[int'(mem_addr)] : init_val(mem_addr);
    if (mem_write) env_mem[int'(mem_addr)] = mem_wdata;
  end

  // Reference model: who held the port last cycle, how long it has held it, who was served most recently.
  logic [7:0] ref_mem [int];
  int   m_prev, m_last, m_streak, m_rv, m_w, m_fs, m_ds;
  logic [7:0] m_rdata;
  logic       obs_f_gnt, obs_d_gnt, obs_f_rv, obs_d_rv, obs_write;
  logic [7:0] obs_rdata, obs_wdata;
  logic [11:0] obs_addr;
  int   obs_fs, obs_ds;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_rd(input logic [11:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic int ref_winner(input logic fr, input logic dr);
    logic other_waits;
    other_waits = (m_prev == 1) ? dr : fr;
    if (m_prev == 1 && fr && !(other_waits && m_streak >= MAX_BURST)) return 1;
    if (m_prev == 2 && dr && !(other_waits && m_streak >= MAX_BURST)) return 2;
    if (fr && dr) return (m_last == 1) ? 2 : 1;
    if (fr) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_prev = 0; m_last = 2; m_streak = 0; m_rv = 0; m_fs = 0; m_ds = 0; m_rdata = '0;
  endtask

  task automatic step(input logic fr, input logic [11:0] fa, input logic dr,
                      input logic [11:0] da, input logic dwe, input logic [7:0] dwd);
    int w;
    f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_we = dwe; d_wdata = dwd;
    @(negedge clk);
    w = ref_winner(fr, dr);
    m_w = w;
    obs_f_gnt = f_gnt; obs_d_gnt = d_gnt; obs_f_rv = f_rvalid; obs_d_rv = d_rvalid;
    obs_rdata = rdata; obs_addr = mem_addr; obs_write = mem_write; obs_wdata = mem_wdata;
    check("f_gnt", 32'(f_gnt), 32'(w == 1));
    check("d_gnt", 32'(d_gnt), 32'(w == 2));
    check("mem_addr", 32'(mem_addr), (w == 1) ? 32'(fa) : (w == 2) ? 32'(da) : 32'd0);
    check("mem_write", 32'(mem_write), 32'(w == 2 && dwe));
    if (w != 1) check("mem_wdata", 32'(mem_wdata), (w == 2) ? 32'(dwd) : 32'd0);
    check("f_rvalid", 32'(f_rvalid), 32'(m_rv == 1));
    check("d_rvalid", 32'(d_rvalid), 32'(m_rv == 2));
    if (m_rv != 0) check("rdata", 32'(rdata), 32'(m_rdata));
`ifdef MEM_ARBITER_PERF_EN
    obs_fs = int'(f_stall); obs_ds = int'(d_stall);
    check("f_stall_cnt", 32'(f_stall), 32'(m_fs));
    check("d_stall_cnt", 32'(d_stall), 32'(m_ds));
`endif
    @(posedge clk);
    if (w == 1) m_rdata = ref_rd(fa);
    if (w == 2 && !dwe) m_rdata = ref_rd(da);
    if (w == 2 && dwe) ref_mem[int'(da)] = dwd;
    m_rv = (w == 1) ? 1 : (w == 2 && !dwe) ? 2 : 0;
    m_streak = (w == 0) ? 0 : (w == m_prev) ? m_streak + 1 : 1;
    m_prev = w;
    if (w != 0) m_last = w;
    if (fr && w != 1 && m_fs < 65535) m_fs++;
    if (dr && w != 2 && m_ds < 65535) m_ds++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f_req = 1'b1; d_req = 1'b1; f_addr = 12'h123; d_addr = 12'h456; d_we = 1'b1; d_wdata = 8'hFF;
    @(negedge clk);
    check("rst_f_gnt", 32'(f_gnt), 0);
    check("rst_d_gnt", 32'(d_gnt), 0);
    check("rst_f_rvalid", 32'(f_rvalid), 0);
    check("rst_d_rvalid", 32'(d_rvalid), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
`ifdef MEM_ARBITER_PERF_EN
    check("rst_f_stall", 32'(f_stall), 0);
    check("rst_d_stall", 32'(d_stall), 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    model_reset();
  endtask

  logic        rf, rd, rwe;
  logic [11:0] rfa, rda;
  logic [7:0]  rwd;

  initial begin
    model_reset();
    do_reset();

    // F alone streams four bytes back-to-back
    for (int i = 0; i < 5; i++) begin
      step(i < 4, 12'(12'h100 + i), 1'b0, '0, 1'b0, '0);
      if (i < 4) check("f_stream_gnt", 32'(obs_f_gnt), 1);
      if (i > 0) begin
        check("f_stream_rvalid", 32'(obs_f_rv), 1);
        check("f_stream_rdata", 32'(obs_rdata), 32'(init_val(12'(12'h100 + i - 1))));
      end
    end

    // Both request from reset: F gets 4, D gets 4, F gets 4
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 12'h200, 1'b1, 12'h300, 1'b0, '0);
      check("rr_pattern", 32'(obs_f_gnt), 32'(((i / 4) % 2) == 0));
      check("rr_exclusive", 32'(obs_f_gnt & obs_d_gnt), 0);
`ifdef MEM_ARBITER_PERF_EN
      if (i == 4) begin
        check("perf_d_wait4", 32'(obs_ds), 4);
        check("perf_f_wait0", 32'(obs_fs), 0);
      end
`endif
    end

    // D write then read back while F idle
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 12'h020, 1'b1, 8'hA5);
    check("wr_mem_write", 32'(obs_write), 1);
    check("wr_mem_addr", 32'(obs_addr), 32'h020);
    check("wr_mem_wdata", 32'(obs_wdata), 32'hA5);
    step(1'b0, '0, 1'b1, 12'h020, 1'b0, '0);
    check("wr_no_rvalid", 32'(obs_d_rv), 0);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);
    check("rd_back_rvalid", 32'(obs_d_rv), 1);
    check("rd_back_data", 32'(obs_rdata), 32'hA5);

    // F drops mid-burst: D takes over in the same cycle, F's last read still returns
    step(1'b1, 12'h140, 1'b0, '0, 1'b0, '0);
    step(1'b1, 12'h141, 1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 12'h050, 1'b0, '0);
    check("drop_d_gnt", 32'(obs_d_gnt), 1);
    check("drop_f_rvalid", 32'(obs_f_rv), 1);
    check("drop_f_rdata", 32'(obs_rdata), 32'(init_val(12'h141)));
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);

    // Reset while an F read is in flight
    step(1'b1, 12'h160, 1'b0, '0, 1'b0, '0);
    do_reset();
    step(1'b1, 12'h161, 1'b1, 12'h061, 1'b0, '0);
    check("post_rst_f_rvalid", 32'(obs_f_rv), 0);
    check("post_rst_tie_f", 32'(obs_f_gnt), 1);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);

    // Long single-requester run saturates the beat count; a late D still gets in
    for (int i = 0; i < 18; i++) step(1'b1, 12'(12'h180 + i), 1'b0, '0, 1'b0, '0);
    step(1'b1, 12'h1A0, 1'b1, 12'h070, 1'b0, '0);
    check("sat_d_gnt", 32'(obs_d_gnt), 1);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);

    // Random traffic; each requester holds its request until granted
    rf = 1'b0; rd = 1'b0; rwe = 1'b0; rfa = '0; rda = '0; rwd = '0;
    for (int n = 0; n < 800; n++) begin
      step(rf, rfa, rd, rda, rwe, rwd);
      if (!rf || m_w == 1) begin
        rf  = ($urandom_range(0, 3) != 0);
        rfa = 12'($urandom_range(0, 31));
      end
      if (!rd || m_w == 2) begin
        rd  = ($urandom_range(0, 3) != 0);
        rda = 12'($urandom_range(0, 31));
        rwe = 1'($urandom_range(0, 1));
        rwd = 8'($urandom);
      end
    end
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);
    step(1'b0, '0, 1'b0, '0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
